decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode_if.sv | 25 ++
 rtl/decode.sv | 145 ++++++++++++++
 tb/tb_decode.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Decode-stage bus: instruction handshake, writeback port from execute, and the issued operand/control outputs.
interface decode_if;
    logic [15:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] wb_data;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] rd_data;
    logic [15:0] s0;
    logic [15:0] im16;
    logic [1:0]  aluctr;
    logic        s2ctr;
    logic        we;
    logic [3:0]  rdest_r;

    modport master (
        output ins, ins_valid, wb_data, wb_we, wb_addr,
        input  ins_ready, rd_data, s0, im16, aluctr, s2ctr, we, rdest_r
    );
    modport slave (
        input  ins, ins_valid, wb_data, wb_we, wb_addr,
        output ins_ready, rd_data, s0, im16, aluctr, s2ctr, we, rdest_r
    );
endinterface

// File: rtl/decode.sv
// Decode stage: 16x16 register file, instruction decode, RAW hazard stall, one-cycle issue register.
// Optional macro WB_BYPASS_EN forwards same-cycle writeback data to operand reads.
module decode (
    input  logic   clk,
    input  logic   rst,
    decode_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;

    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];
    logic [15:0] rd_data_q, rd_data_d;
    logic [15:0] s0_q, s0_d;
    logic [15:0] im16_q, im16_d;
    logic [1:0]  aluctr_q, aluctr_d;
    logic        s2ctr_q, s2ctr_d;
    logic        we_q, we_d;
    logic [3:0]  rdest_r_q, rdest_r_d;

    logic [3:0]  op, rd, rs, rt, op_m1;
    logic [7:0]  imm8;
    logic [15:0] val_rs, val_rt, val_rd;
    logic        hazard, accept;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        logic signed [7:0]  narrow;
        logic signed [15:0] wide;
        narrow = v;
        wide   = narrow;
        return wide;
    endfunction

    // True when register a is a source actually read by opcode o.
    function automatic logic src_match(input logic [3:0] a, input logic [3:0] o,
                                       input logic [3:0] d, input logic [3:0] s,
                                       input logic [3:0] t);
        logic r_type;
        r_type = (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR);
        return (r_type && ((a == s) || (a == t))) || ((o == OP_ADDI) && (a == d));
    endfunction

    assign op    = bus.ins[15:12];
    assign rd    = bus.ins[11:8];
    assign rs    = bus.ins[7:4];
    assign rt    = bus.ins[3:0];
    assign imm8  = bus.ins[7:0];
    assign op_m1 = op - 4'd1;

`ifdef WB_BYPASS_EN
    always_comb begin
        val_rs = (bus.wb_we && (bus.wb_addr == rs)) ? bus.wb_data : regs_q[rs];
        val_rt = (bus.wb_we && (bus.wb_addr == rt)) ? bus.wb_data : regs_q[rt];
        val_rd = (bus.wb_we && (bus.wb_addr == rd)) ? bus.wb_data : regs_q[rd];
    end

    assign hazard = we_q && src_match(rdest_r_q, op, rd, rs, rt);
`else
    always_comb begin
        val_rs = regs_q[rs];
        val_rt = regs_q[rt];
        val_rd = regs_q[rd];
    end

    // Without forwarding, a write landing this edge is not yet visible in the file.
    assign hazard = (we_q && src_match(rdest_r_q, op, rd, rs, rt)) ||
                    (bus.wb_we && src_match(bus.wb_addr, op, rd, rs, rt));
`endif

    assign bus.ins_ready = rst & ~hazard;
    assign accept        = bus.ins_valid & bus.ins_ready;

    always_comb begin
        regs_d = regs_q;
        if (bus.wb_we) regs_d[bus.wb_addr] = bus.wb_data;
    end

    // Default is a bubble; an accepted instruction overrides only the fields it drives.
    always_comb begin
        s0_d      = '0;
        rd_data_d = '0;
        im16_d    = '0;
        aluctr_d  = '0;
        s2ctr_d   = 1'b0;
        we_d      = 1'b0;
        rdest_r_d = '0;
        if (accept) begin
            rdest_r_d = rd;
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    s0_d      = val_rs;
                    rd_data_d = val_rt;
                    aluctr_d  = op_m1[1:0];
                    we_d      = 1'b1;
                end
                OP_ADDI: begin
                    s0_d    = val_rd;
                    im16_d  = sext8(imm8);
                    s2ctr_d = 1'b1;
                    we_d    = 1'b1;
                end
                OP_LDI: begin
                    im16_d  = sext8(imm8);
                    s2ctr_d = 1'b1;
                    we_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            rd_data_q <= '0;
            s0_q      <= '0;
            im16_q    <= '0;
            aluctr_q  <= '0;
            s2ctr_q   <= 1'b0;
            we_q      <= 1'b0;
            rdest_r_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
            s0_q      <= s0_d;
            im16_q    <= im16_d;
            aluctr_q  <= aluctr_d;
            s2ctr_q   <= s2ctr_d;
            we_q      <= we_d;
            rdest_r_q <= rdest_r_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.s0      = s0_q;
    assign bus.im16    = im16_q;
    assign bus.aluctr  = aluctr_q;
    assign bus.s2ctr   = s2ctr_q;
    assign bus.we      = we_q;
    assign bus.rdest_r = rdest_r_q;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: each step pushes the expected issue-register contents, pops and checks after the edge.
module tb_decode;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    decode_if bus ();

    decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] s0;
        logic [15:0] rd_data;
        logic [15:0] im16;
        logic [1:0]  aluctr;
        logic        s2ctr;
        logic        we;
        logic [3:0]  rdest;
        logic [3:0]  mask;   // [0] s0, [1] rd_data, [2] im16, [3] aluctr/s2ctr/rdest; we always checked
    } exp_t;

    exp_t sb [$];

    function automatic exp_t bubble(input string tag);
        exp_t e;
        e.tag = tag; e.s0 = '0; e.rd_data = '0; e.im16 = '0;
        e.aluctr = '0; e.s2ctr = 1'b0; e.we = 1'b0; e.rdest = '0; e.mask = 4'hF;
        return e;
    endfunction

    function automatic exp_t rtype(input string tag, input logic [15:0] s0, input logic [15:0] rdv,
                                   input logic [1:0] alu, input logic [3:0] rdest);
        exp_t e;
        e.tag = tag; e.s0 = s0; e.rd_data = rdv; e.im16 = '0;
        e.aluctr = alu; e.s2ctr = 1'b0; e.we = 1'b1; e.rdest = rdest; e.mask = 4'b1011;
        return e;
    endfunction

    function automatic exp_t itype(input string tag, input logic [15:0] s0, input logic [15:0] im,
                                   input logic [3:0] rdest);
        exp_t e;
        e.tag = tag; e.s0 = s0; e.rd_data = '0; e.im16 = im;
        e.aluctr = 2'b00; e.s2ctr = 1'b1; e.we = 1'b1; e.rdest = rdest; e.mask = 4'b1101;
        return e;
    endfunction

    function automatic exp_t nop(input string tag);
        exp_t e;
        e = bubble(tag);
        e.mask = 4'b0000;
        return e;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; ready is checked just after, outputs 1 time unit after the rising edge.
    task automatic step(input logic exp_ready, input exp_t e);
        exp_t g;
        sb.push_back(e);
        #1;
        chk(e.tag, "ins_ready", {15'b0, bus.ins_ready}, {15'b0, exp_ready});
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk(g.tag, "we", {15'b0, bus.we}, {15'b0, g.we});
        if (g.mask[0]) chk(g.tag, "s0", bus.s0, g.s0);
        if (g.mask[1]) chk(g.tag, "rd_data", bus.rd_data, g.rd_data);
        if (g.mask[2]) chk(g.tag, "im16", bus.im16, g.im16);
        if (g.mask[3]) begin
            chk(g.tag, "aluctr", {14'b0, bus.aluctr}, {14'b0, g.aluctr});
            chk(g.tag, "s2ctr", {15'b0, bus.s2ctr}, {15'b0, g.s2ctr});
            chk(g.tag, "rdest_r", {12'b0, bus.rdest_r}, {12'b0, g.rdest});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic valid, input logic [15:0] ins,
                         input logic wbwe, input logic [3:0] wba, input logic [15:0] wbd);
        bus.ins_valid = valid;
        bus.ins       = ins;
        bus.wb_we     = wbwe;
        bus.wb_addr   = wba;
        bus.wb_data   = wbd;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
        @(negedge clk);

        // Reset beats a writeback and a valid instruction.
        drive(1'b1, 16'h6385, 1'b1, 4'h1, 16'hBEEF);
        step(1'b0, bubble("reset"));
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000);
        step(1'b1, bubble("post_reset"));

        // r1/r2 still zero: the write during reset was dropped.
        drive(1'b1, 16'h1012, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("add_zero", 16'h0000, 16'h0000, 2'b00, 4'h0));
        drive(1'b1, 16'h6385, 1'b0, 4'h0, 16'h0000);
        step(1'b1, itype("ldi", 16'h0000, 16'hFF85, 4'h3));

        drive(1'b0, 16'h6385, 1'b1, 4'h1, 16'h5555);
        step(1'b1, bubble("wb_r1"));
        drive(1'b0, 16'h6385, 1'b1, 4'h2, 16'h7777);
        step(1'b1, bubble("wb_r2"));

        drive(1'b1, 16'h1412, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("add", 16'h5555, 16'h7777, 2'b00, 4'h4));
        drive(1'b1, 16'h2541, 1'b0, 4'h0, 16'h0000);
        step(1'b0, bubble("stall1"));
        drive(1'b1, 16'h2541, 1'b1, 4'h4, 16'hCCCC);
`ifdef WB_BYPASS_EN
        step(1'b1, rtype("sub_fwd", 16'hCCCC, 16'h5555, 2'b01, 4'h5));
        drive(1'b0, 16'h1412, 1'b0, 4'h0, 16'h0000);
`else
        step(1'b0, bubble("stall2"));
        drive(1'b1, 16'h2541, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("sub", 16'hCCCC, 16'h5555, 2'b01, 4'h5));
        drive(1'b0, 16'h1412, 1'b0, 4'h0, 16'h0000);
`endif
        step(1'b1, bubble("no_valid"));
        drive(1'b1, 16'hF123, 1'b0, 4'h0, 16'h0000);
        step(1'b1, nop("nop_f"));

        drive(1'b1, 16'h5100, 1'b1, 4'h1, 16'h1234);
`ifdef WB_BYPASS_EN
        step(1'b1, itype("addi_fwd", 16'h1234, 16'h0000, 4'h1));
`else
        step(1'b0, bubble("addi_wait"));
        drive(1'b1, 16'h5100, 1'b0, 4'h0, 16'h0000);
        step(1'b1, itype("addi", 16'h1234, 16'h0000, 4'h1));
`endif

        // r0 behaves as an ordinary register.
        drive(1'b0, 16'h0000, 1'b1, 4'h0, 16'h0F0F);
        step(1'b1, bubble("wb_r0"));
        drive(1'b1, 16'h1001, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("add_r0", 16'h0F0F, 16'h1234, 2'b00, 4'h0));

        // Reset in the middle of a stall drops the held instruction and clears the file.
        drive(1'b1, 16'h2301, 1'b0, 4'h0, 16'h0000);
        step(1'b0, bubble("stall_r0"));
        rst = 1'b0;
        step(1'b0, bubble("reset_mid_stall"));
        rst = 1'b1;
        drive(1'b1, 16'h3201, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("and_after_reset", 16'h0000, 16'h0000, 2'b10, 4'h2));
        drive(1'b1, 16'h4765, 1'b0, 4'h0, 16'h0000);
        step(1'b1, rtype("or", 16'h0000, 16'h0000, 2'b11, 4'h7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
